// File: rtl/uart_tx_pkg.sv
// Shared types and line levels for the UART transmit path.
// UART_TX_STOP2_EN adds a STOP2 state for two stop bits per frame.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
`ifdef UART_TX_STOP2_EN
        ,
        STOP2
`endif
    } state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_mux.sv
// Selects the next serial line level from the frame state.
// UART_TX_STOP2_EN makes the STOP2 state drive the stop level.
module uart_tx_mux
    import uart_tx_pkg::*;
(
    input  state_t state,
    input  logic   data_bit,
    input  logic   parity_bit,
    output logic   tx_next
);

    always_comb begin
        tx_next = IDLE_LEVEL;
        case (state)
            IDLE:    tx_next = IDLE_LEVEL;
            START:   tx_next = START_BIT;
            DATA:    tx_next = data_bit;
            PARITY:  tx_next = parity_bit;
            STOP:    tx_next = STOP_BIT;
`ifdef UART_TX_STOP2_EN
            STOP2:   tx_next = STOP_BIT;
`endif
            default: tx_next = IDLE_LEVEL;
        endcase
    end

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmit frame controller: latches a word, serializes start/data/parity/stop.
// UART_TX_STOP2_EN selects two stop bits per frame.
module uart_tx_fsm
    import uart_tx_pkg::*;
#(
    parameter int Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] P_DATA,
    input  logic             Data_valid,
    input  logic             PAR_EN,
    input  logic             PAR_TYP,
    input  logic             parity_bit,
    output logic [Width-1:0] par_data,
    output logic             par_type,
    output logic             TX_OUT,
    output logic             busy
);

    localparam int CW = (Width > 1) ? $clog2(Width) : 1;
    localparam logic [CW-1:0] LAST = CW'(Width - 1);

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] cnt;
    logic          par_en_q;
    logic          parity_q;
    logic          tx_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (Data_valid) next_state = START;
            START:   next_state = DATA;
            DATA:    if (cnt == LAST) next_state = par_en_q ? PARITY : STOP;
            PARITY:  next_state = STOP;
`ifdef UART_TX_STOP2_EN
            STOP:    next_state = STOP2;
            STOP2:   next_state = IDLE;
`else
            STOP:    next_state = IDLE;
`endif
            default: next_state = IDLE;
        endcase
    end

    // parity_bit is captured on the last data bit, when the parity stage has long settled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            par_data <= '0;
            par_type <= 1'b0;
            par_en_q <= 1'b0;
            parity_q <= 1'b0;
        end else begin
            if (state == IDLE && Data_valid) begin
                par_data <= P_DATA;
                par_type <= PAR_TYP;
                par_en_q <= PAR_EN;
            end
            if (state == DATA) begin
                if (cnt == LAST) begin
                    cnt      <= '0;
                    parity_q <= parity_bit;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

    uart_tx_mux u_mux (
        .state      (state),
        .data_bit   (par_data[cnt]),
        .parity_bit (parity_q),
        .tx_next    (tx_next)
    );

    // Outputs lag the state by one cycle so both change on the same edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            TX_OUT <= IDLE_LEVEL;
            busy   <= 1'b0;
        end else begin
            TX_OUT <= tx_next;
            busy   <= (state != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Self-checking bench for uart_tx_fsm with a registered parity-stage model.
// Define UART_TX_STOP2_EN to check the two-stop-bit build.
module tb_uart_tx_fsm;

    localparam int W = 8;
`ifdef UART_TX_STOP2_EN
    localparam int STOPS = 2;
`else
    localparam int STOPS = 1;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] P_DATA = '0;
    logic         Data_valid = 1'b0;
    logic         PAR_EN = 1'b0;
    logic         PAR_TYP = 1'b0;
    logic         parity_bit = 1'b0;
    logic [W-1:0] par_data;
    logic         par_type;
    logic         TX_OUT;
    logic         busy;

    int tests = 0;
    int fails = 0;
    logic exp_q[$];

    uart_tx_fsm #(.Width(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (P_DATA),
        .Data_valid (Data_valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .parity_bit (parity_bit),
        .par_data   (par_data),
        .par_type   (par_type),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Upstream parity calculator: registered, odd when par_type = 1
    always @(posedge clk) parity_bit <= par_type ? ~^par_data : ^par_data;

    function automatic void push_frame(input logic [W-1:0] d, input logic pe, input logic pt);
        exp_q.push_back(1'b0);
        for (int i = 0; i < W; i++) exp_q.push_back(d[i]);
        if (pe) exp_q.push_back(pt ? ~^d : ^d);
        for (int i = 0; i < STOPS; i++) exp_q.push_back(1'b1);
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            tests++;
            if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
                fails++;
                $display("FAIL reset_idle cycle %0d: tx=%b busy=%b, required tx=1 busy=0", c, TX_OUT, busy);
            end
        end
        tests++;
        if (par_data !== '0 || par_type !== 1'b0) begin
            fails++;
            $display("FAIL reset_latch: par_data=%h par_type=%b, required 00/0", par_data, par_type);
        end
    endtask

    task automatic test_frame(input logic [W-1:0] d, input logic pe, input logic pt);
        int unsigned len;
        logic e;
        len = 0;
        push_frame(d, pe, pt);
        P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Data_valid = 1'b1;
        @(posedge clk); #1;
        Data_valid = 1'b0; P_DATA = ~d; PAR_EN = ~pe; PAR_TYP = ~pt;
        tests++;
        if (busy !== 1'b0 || TX_OUT !== 1'b1) begin
            fails++;
            $display("FAIL latency %h: busy=%b tx=%b one edge after accept, required 0/1", d, busy, TX_OUT);
        end
        tests++;
        if (par_data !== d || par_type !== pt) begin
            fails++;
            $display("FAIL latch %h: par_data=%h par_type=%b, required %h/%b", d, par_data, par_type, d, pt);
        end
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (busy !== 1'b1) break;
            len++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
            tests++;
            if (TX_OUT !== e) begin
                fails++;
                $display("FAIL frame %h bit %0d: tx=%b, required %b", d, len - 1, TX_OUT, e);
            end
        end
        tests++;
        if (len != 1 + W + int'(pe) + STOPS) begin
            fails++;
            $display("FAIL busy_len %h: %0d cycles, required %0d", d, len, 1 + W + int'(pe) + STOPS);
        end
        tests++;
        if (TX_OUT !== 1'b1 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL frame_end %h: tx=%b pending=%0d, required tx=1 pending=0", d, TX_OUT, exp_q.size());
        end
        exp_q.delete();
        PAR_EN = 1'b0; PAR_TYP = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] w;
        logic e;
        PAR_EN = 1'b0; PAR_TYP = 1'b0;
        P_DATA = '0; Data_valid = 1'b1;
        @(posedge clk); #1;
        for (int f = 0; f < 4; f++) begin
            w = (f % 2 == 1) ? '1 : '0;
            P_DATA = ~w;
            push_frame(w, 1'b0, 1'b0);
            for (int i = 0; i < 1 + W + STOPS; i++) begin
                @(posedge clk); #1;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
                tests++;
                if (TX_OUT !== e || busy !== 1'b1) begin
                    fails++;
                    $display("FAIL b2b frame %0d bit %0d: tx=%b busy=%b, required tx=%b busy=1", f, i, TX_OUT, busy, e);
                end
            end
            @(posedge clk); #1;
            tests++;
            if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
                fails++;
                $display("FAIL b2b gap %0d: tx=%b busy=%b, required tx=1 busy=0", f, TX_OUT, busy);
            end
        end
        Data_valid = 1'b0;
        exp_q.delete();
        repeat (1 + W + STOPS + 1) @(posedge clk);
        #1;
        tests++;
        if (busy !== 1'b0 || TX_OUT !== 1'b1) begin
            fails++;
            $display("FAIL b2b drain: busy=%b tx=%b, required 0/1", busy, TX_OUT);
        end
    endtask

    task automatic test_async_reset();
        P_DATA = 8'h96; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_valid = 1'b1;
        @(posedge clk); #1;
        Data_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        tests++;
        if (TX_OUT !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL pre_abort data bit 3: tx=%b busy=%b, required 0/1", TX_OUT, busy);
        end
        #2 rst = 1'b0;
        #1;
        tests++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0 || par_data !== '0) begin
            fails++;
            $display("FAIL async_abort: tx=%b busy=%b par_data=%h, required 1/0/00", TX_OUT, busy, par_data);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        PAR_EN = 1'b0;
        test_frame(8'h3C, 1'b1, 1'b1);
    endtask

    initial begin
        test_reset();
        test_frame(8'hA5, 1'b1, 1'b0);
        test_frame(8'hA5, 1'b1, 1'b1);
        test_frame(8'h07, 1'b0, 1'b0);
        test_back_to_back();
        test_async_reset();
        test_frame(8'h55, 1'b1, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
